// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared FSM state encoding and port identifiers for dram_arbiter
package dram_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        DONE  = 2'd3
    } state_t;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/dram_arb_pick.sv
// dram_arb_pick: combinational grant selector for the two RAM requesters
//   a_req, b_req : pending requests
//   last_grant   : port served most recently (consulted only when DRAM_ARB_RR_EN is defined)
//   grant_id     : winning port; don't-care when neither port requests
// DRAM_ARB_RR_EN defined: round-robin on contention. Undefined: A has fixed priority over B.
module dram_arb_pick
    import dram_arb_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
    input  logic last_grant,
    output logic grant_id
);
`ifdef DRAM_ARB_RR_EN
    always_comb grant_id = (a_req && b_req) ? ~last_grant : (a_req ? PORT_A : PORT_B);
`else
    logic unused_last_grant;
    always_comb begin
        unused_last_grant = last_grant;
        grant_id          = (a_req || !b_req) ? PORT_A : PORT_B;
    end
`endif
endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: two-port req/ack arbiter and sequencer for a single-port RAM
//   clock, reset           : rising-edge clock, asynchronous active-high reset
//   a_* / b_*              : req, we, addr, wdata in; one-cycle ack and rdata (valid with ack) out
//   ram_addr, ram_wd, ram_we : registered RAM drive; ram_q is the unregistered RAM read data
//   busy                   : high whenever a transaction is in flight
// DRAM_ARB_RR_EN selects round-robin arbitration; default is fixed priority A over B.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wd,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);
    state_t state, state_nx;
    logic   grant_id, win_id, last_grant, start;

    assign start = state == IDLE && (a_req || b_req);

    dram_arb_pick u_pick (
        .a_req      (a_req),
        .b_req      (b_req),
        .last_grant (last_grant),
        .grant_id   (grant_id)
    );

`ifdef DRAM_ARB_RR_EN
    always_ff @(posedge clock or posedge reset)
        if (reset) last_grant <= PORT_B;
        else if (start) last_grant <= grant_id;
`else
    assign last_grant = PORT_B;
`endif

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;

    // ram_we is the latched write flag, so it doubles as the write/read decision in ISSUE
    always_comb begin
        state_nx = state == IDLE  ? ((a_req || b_req) ? ISSUE : IDLE) :
                   state == ISSUE ? (ram_we ? DONE : CAPT) :
                   state == CAPT  ? DONE : IDLE;
        busy     = state != IDLE;
        a_ack    = state == DONE && win_id == PORT_A;
        b_ack    = state == DONE && win_id == PORT_B;
    end

    // ram_we is set only by the IDLE->ISSUE edge, so it is high for exactly the ISSUE cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_id   <= PORT_A;
            ram_addr <= '0;
            ram_wd   <= '0;
            ram_we   <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            ram_we <= start && (grant_id == PORT_A ? a_we : b_we);
            if (start) begin
                win_id   <= grant_id;
                ram_addr <= grant_id == PORT_A ? a_addr : b_addr;
                ram_wd   <= grant_id == PORT_A ? a_wdata : b_wdata;
            end
            if (state == CAPT && win_id == PORT_A) a_rdata <= ram_q;
            if (state == CAPT && win_id == PORT_B) b_rdata <= ram_q;
        end
    end
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed vectors, corner sequences and random traffic against a transaction model
module tb_dram_arbiter;
    logic        clock = 1'b0, reset = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [15:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
    logic        a_ack, b_ack, ram_we, busy;
    logic [15:0] a_rdata, b_rdata, ram_addr, ram_wd, ram_q;
    int          errs = 0, checks = 0;

    dram_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_wd(ram_wd), .ram_we(ram_we), .ram_q(ram_q), .busy(busy)
    );

    always #5 clock = ~clock;

    // RAM macro: registered address/data/we, unregistered read of the registered address
    logic [15:0] mem [0:65535];
    logic [15:0] raddr = '0;
    bit          mem_loaded = 1'b0;
    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 16'(i) ^ 16'h5A5A;
            mem_loaded <= 1'b1;
        end else if (ram_we) mem[ram_addr] <= ram_wd;
        raddr <= ram_addr;
    end
    assign ram_q = mem[raddr];

    // reference contents: initial pattern overlaid with every write the model accepts
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] exp_rd [2];

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'h5A5A);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic p, input logic r, input logic w, input logic [15:0] ad, input logic [15:0] wd);
        if (p) begin b_req = r; b_we = w; b_addr = ad; b_wdata = wd; end
        else begin a_req = r; a_we = w; a_addr = ad; a_wdata = wd; end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] rdata;
    } vec_t;

    // one isolated transaction: latency, single ack pulse, write strobe and both rdata ports
    task automatic run_txn(input vec_t v, input string tag);
        int          lat = 0, acks = 0, wes = 0, other = 0;
        logic [15:0] wa = '0, wd = '0;
        @(negedge clock);
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clock);
            if (v.port ? b_ack : a_ack) begin
                acks++;
                if (lat == 0) lat = c;
                drive(v.port, 1'b0, 1'b0, 16'h0, 16'h0);
            end
            if (v.port ? a_ack : b_ack) other++;
            if (ram_we) begin wes++; wa = ram_addr; wd = ram_wd; end
        end
        if (v.we) ref_mem[v.addr] = v.wdata;
        else exp_rd[v.port] = v.rdata;
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " ack pulses"}, acks, 1);
        chk({tag, " other ack"}, other, 0);
        chk({tag, " ram_we cycles"}, wes, {31'b0, v.we});
        if (v.we) begin
            chk({tag, " ram_addr"}, wa, v.addr);
            chk({tag, " ram_wd"}, wd, v.wdata);
        end
        chk({tag, " a_rdata"}, a_rdata, exp_rd[0]);
        chk({tag, " b_rdata"}, b_rdata, exp_rd[1]);
    endtask

    // random-phase model state
    logic        rq [2], rw [2];
    logic [15:0] ra [2], rd [2];
    bit          m_act, was;
    int          m_left;
    logic        m_port, m_we, m_last;
    logic [15:0] m_addr, m_wd, m_rv;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [6];
        int   a_lat, b_lat, n, ord [6], at [6], acks, wes;
        vecs[0] = '{1'b0, 1'b1, 16'h0010, 16'h1234, 3, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 4, 16'h1234};
        vecs[2] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 4, 16'h5AA5};
        vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 3, 16'h0000};
        vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 4, 16'hFFFF};
        vecs[5] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 4, 16'h5A5B};
        exp_rd[0] = '0;
        exp_rd[1] = '0;

        repeat (2) @(negedge clock);
        chk("reset a_ack", a_ack, 0);
        chk("reset b_ack", b_ack, 0);
        chk("reset a_rdata", a_rdata, 0);
        chk("reset b_rdata", b_rdata, 0);
        chk("reset ram_addr", ram_addr, 0);
        chk("reset ram_wd", ram_wd, 0);
        chk("reset ram_we", ram_we, 0);
        chk("reset busy", busy, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // simultaneous requests after an A-only grant
        do_reset();
        run_txn('{1'b0, 1'b1, 16'h0003, 16'h0333, 3, 16'h0000}, "pre-sim");
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000);
        drive(1'b1, 1'b1, 1'b1, 16'h0002, 16'hBEEF);
        a_lat = 0;
        b_lat = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clock);
            if (a_ack && a_lat == 0) begin a_lat = c; a_req = 1'b0; end
            if (b_ack && b_lat == 0) begin b_lat = c; b_req = 1'b0; end
        end
        ref_mem[16'h0002] = 16'hBEEF;
        exp_rd[0] = 16'h5A5B;
`ifdef DRAM_ARB_RR_EN
        chk("sim a ack cycle", a_lat, 7);
        chk("sim b ack cycle", b_lat, 3);
`else
        chk("sim a ack cycle", a_lat, 4);
        chk("sim b ack cycle", b_lat, 7);
`endif
        chk("sim a_rdata", a_rdata, exp_rd[0]);
        chk("sim b_rdata", b_rdata, exp_rd[1]);

        // both ports hold write requests continuously for six grants
        do_reset();
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b1, 16'h0100, 16'h1111);
        drive(1'b1, 1'b1, 1'b1, 16'h0101, 16'h2222);
        n = 0;
        for (int k = 0; k < 6; k++) begin ord[k] = -1; at[k] = 0; end
        for (int c = 1; c <= 40 && n < 6; c++) begin
            if (c > 1) @(negedge clock);
            if (a_ack || b_ack) begin
                ord[n] = b_ack ? 1 : 0;
                at[n] = c;
                n++;
                if (n == 6) begin a_req = 1'b0; b_req = 1'b0; end
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (4) @(negedge clock);
        ref_mem[16'h0100] = 16'h1111;
`ifdef DRAM_ARB_RR_EN
        ref_mem[16'h0101] = 16'h2222;
`endif
        for (int k = 0; k < 6; k++) begin
`ifdef DRAM_ARB_RR_EN
            chk($sformatf("alt grant%0d", k), ord[k], k % 2);
`else
            chk($sformatf("alt grant%0d", k), ord[k], 0);
`endif
            if (k > 0) chk($sformatf("alt spacing%0d", k), at[k] - at[k-1], 3);
        end

        // request dropped and inputs changed right after the grant
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 16'h00FF, 16'h0000);
        a_lat = 0;
        acks = 0;
        wes = 0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clock);
            if (c == 2) drive(1'b0, 1'b0, 1'b1, 16'h0040, 16'h7777);
            if (a_ack) begin acks++; if (a_lat == 0) a_lat = c; end
            if (ram_we) wes++;
        end
        exp_rd[0] = ref_rd(16'h00FF);
        chk("drop latency", a_lat, 4);
        chk("drop ack pulses", acks, 1);
        chk("drop ram_we cycles", wes, 0);
        chk("drop a_rdata", a_rdata, exp_rd[0]);

        // reset asserted during the ISSUE cycle of a write
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b1, 16'h0020, 16'h5555);
        @(negedge clock);
        chk("rst-issue ram_we before", ram_we, 1);
        chk("rst-issue busy before", busy, 1);
        #1 reset = 1'b1;
        #1;
        chk("rst-issue ram_we", ram_we, 0);
        chk("rst-issue busy", busy, 0);
        a_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (a_ack) acks++;
        end
        chk("rst-issue no ack", acks, 0);
        run_txn('{1'b0, 1'b0, 16'h0020, 16'h0000, 4, 16'h5A7A}, "rst-issue readback");

        // random traffic against the transaction-level model
        do_reset();
        m_act = 1'b0;
        m_left = 0;
        m_last = 1'b1;
        m_addr = '0;
        m_wd = '0;
        m_we = 1'b0;
        m_port = 1'b0;
        m_rv = '0;
        for (int p = 0; p < 2; p++) begin rq[p] = 1'b0; rw[p] = 1'b0; ra[p] = '0; rd[p] = '0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            if (m_act) m_left--;
            if (m_act && m_left == 0 && !m_we) exp_rd[m_port] = m_rv;
            chk("rnd a_ack", a_ack, {31'b0, m_act && m_left == 0 && m_port == 1'b0});
            chk("rnd b_ack", b_ack, {31'b0, m_act && m_left == 0 && m_port == 1'b1});
            chk("rnd busy", busy, {31'b0, m_act});
            chk("rnd ram_we", ram_we, {31'b0, m_act && m_we && m_left == 1});
            chk("rnd ram_addr", ram_addr, m_addr);
            if (m_act && m_we) chk("rnd ram_wd", ram_wd, m_wd);
            chk("rnd a_rdata", a_rdata, exp_rd[0]);
            chk("rnd b_rdata", b_rdata, exp_rd[1]);
            was = m_act;
            if (m_act && m_left == 0) m_act = 1'b0;
            for (int p = 0; p < 2; p++) begin
                automatic bit done = was && m_left == 0 && m_port == 1'(p);
                automatic bit idle = !rq[p];
                if (done) rq[p] = $urandom_range(0, 2) == 0;
                else if (idle) rq[p] = 1'($urandom_range(0, 1));
                if (done || idle || $urandom_range(0, 3) == 0) begin
                    rw[p] = 1'($urandom_range(0, 1));
                    ra[p] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 7));
                    rd[p] = 16'($urandom);
                end
                drive(1'(p), rq[p], rw[p], ra[p], rd[p]);
            end
            if (!was && (rq[0] || rq[1])) begin
`ifdef DRAM_ARB_RR_EN
                m_port = (rq[0] && rq[1]) ? ~m_last : (rq[0] ? 1'b0 : 1'b1);
                m_last = m_port;
`else
                m_port = rq[0] ? 1'b0 : 1'b1;
`endif
                m_we = rw[m_port];
                m_addr = ra[m_port];
                m_wd = rd[m_port];
                if (m_we) ref_mem[m_addr] = m_wd;
                else m_rv = ref_rd(m_addr);
                m_left = m_we ? 2 : 3;
                m_act = 1'b1;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (6) @(negedge clock);
        chk("end busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data RAM (16-bit words, 16-bit address).
- The RAM registers address, data and write-enable on the clock edge; its read output is unregistered.
- Shares the RAM between the CPU core (port A) and an auxiliary loader/debug master (port B). Each port uses a req/ack handshake.
- Sits between the CPU and the RAM macro and owns every RAM control signal.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 16, RAM data width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- a_req  in  1  port A request; held until a_ack
- a_we  in  1  port A: 1 = write, 0 = read
- a_addr  in  ADDR_W  port A address
- a_wdata  in  DATA_W  port A write data
- a_ack  out  1  port A one-cycle completion pulse
- a_rdata  out  DATA_W  port A read data; valid while a_ack=1
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as port A, for port B
- ram_addr  out  ADDR_W  to RAM address
- ram_wd  out  DATA_W  to RAM data
- ram_we  out  1  to RAM write enable
- ram_q  in  DATA_W  RAM read data (unregistered)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant = B (so A is favoured first).
- Reset is asynchronous. When it asserts mid-transaction, ram_we drops immediately, no ack is issued, and the transaction is lost.
- States:
  - IDLE -> ISSUE when any req=1. Latch the winner's id, we, addr and wdata into internal registers. Those registers then drive ram_addr, ram_wd and ram_we (all registered outputs).
  - ISSUE: ram_addr, ram_wd and ram_we hold the latched values; the RAM samples them at the end of this cycle. Write -> DONE. Read -> CAPT.
  - CAPT: ram_we=0. ram_q is valid this cycle; latch it into the winner's rdata register. -> DONE.
  - DONE: winner's ack=1 for exactly one cycle, with rdata stable. ram_we=0. -> IDLE.
- ram_we is high only during ISSUE of a write; it is 0 in every other state.
- ram_addr holds its last value outside ISSUE. It is not cleared.
- Latency, counted from the first cycle req is high with the arbiter in IDLE:
  - Write: ack in cycle 3.
  - Read: ack in cycle 4.
- Back-to-back: a requester whose req is still high in the cycle after DONE is re-arbitrated in IDLE. Minimum spacing between acks: 3 cycles for writes, 4 for reads.
- Arbitration happens only in IDLE. Default policy is fixed priority: A beats B.
- Inputs are sampled only at the IDLE->ISSUE edge. Later changes to addr, wdata or we, or req dropping before ack, do not affect the transaction in flight. It still completes and acks.
- rdata for each port holds its value until that port's next read completes. Writes do not alter rdata.
- The losing requester keeps req high and is served next. Under fixed priority, B can starve while A requests continuously; this is accepted.
- Address and data pass through unmodified, with no arithmetic and no wrap logic. Address 0xFFFF is legal.

Optional Feature:
- Macro: DRAM_ARB_RR_EN.
- Defined: round-robin arbitration. When both ports request in IDLE, the port that did not win last time wins. last_grant updates on each IDLE->ISSUE transition. When only one port requests, it wins regardless of last_grant.
- Undefined: fixed priority, A over B. The last_grant register is not present.

Decomposition:
- Shared package dram_arb_pkg holds:
  - state enum: IDLE=2'd0, ISSUE=2'd1, CAPT=2'd2, DONE=2'd3
  - port-id constants: PORT_A=1'b0, PORT_B=1'b1
- One sub-module, dram_arb_pick: a combinational grant selector with inputs a_req, b_req, last_grant and output grant_id. It contains the DRAM_ARB_RR_EN conditional.
- Everything else (FSM, latches, RAM drive) lives in the top module.

Test Plan:
- A write then A read: A writes 0x1234 to 0x0010, then reads 0x0010. Expect ram_we=1 for exactly one cycle with ram_addr=0x0010, a_ack in cycle 3, then a_ack in cycle 4 with a_rdata=0x1234. b_ack stays 0.
- Simultaneous requests: A reads 0x0001 and B writes 0xBEEF to 0x0002 in the same cycle. Fixed priority: A is acked first, then B. With DRAM_ARB_RR_EN and last_grant=A, B is acked first.
- Round-robin alternation (DRAM_ARB_RR_EN): A and B both hold req continuously for 6 transactions. Grants alternate A,B,A,B,A,B. Without the macro, all 6 grants go to A.
- Req dropped early: A requests a read of 0x00FF and drops a_req in the cycle after IDLE. The read still completes, a_ack pulses once, and a_rdata = RAM[0x00FF].
- Reset during ISSUE of a write: assert reset during the ISSUE cycle of a write of 0x5555 to 0x0020. ram_we=0 within the same cycle, no ack, busy=0. A later read of 0x0020 returns the pre-reset contents.
- Boundary address: B writes 0xFFFF to address 0xFFFF, then reads it back. Expect b_rdata=0xFFFF, and A's a_rdata is unchanged from its previous value.
